// File: rtl/frame_mem_arbiter.sv
// frame_mem_arbiter: time-shares one single-port synchronous pixel RAM
// (1-cycle read latency) between the camera write FIFO and the VGA read FIFO.
// Transfers are fixed-length bursts, arbitrated in a one-cycle IDLE slot.
// An urgent read FIFO always wins. Otherwise, when both sides are eligible,
// the grant alternates between them. Each side keeps its own frame address
// counter. Frame-start pulses are held pending and are applied only in IDLE.
//
// Handshake: oWR_POP and oRD_PUSH are single-cycle strobes. Each one moves
// exactly one word in the cycle where it is high. There is no ready/stall
// inside a burst. Eligibility (enough words or space for a full burst) is
// checked once in IDLE, so a granted burst always runs to completion.
// oMEM_WDATA and oRD_DATA are zero whenever their strobe is low.
module frame_mem_arbiter #(
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 16,
  parameter int LVL_W       = 10,
  parameter int BURST_LEN   = 8,
  parameter int FRAME_WORDS = 307200,
  parameter int RD_URGENT   = 768
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [LVL_W-1:0]  iWR_LEVEL,
  input  logic [DATA_W-1:0] iWR_DATA,
  output logic              oWR_POP,
  input  logic              iWR_FRAME_START,
  input  logic [LVL_W-1:0]  iRD_SPACE,
  output logic              oRD_PUSH,
  output logic [DATA_W-1:0] oRD_DATA,
  input  logic              iRD_FRAME_START,
  output logic [ADDR_W-1:0] oMEM_ADDR,
  output logic              oMEM_WE,
  output logic [DATA_W-1:0] oMEM_WDATA,
  input  logic [DATA_W-1:0] iMEM_RDATA,
  output logic [1:0]        oGRANT,
  output logic [1:0]        oDBG_STATE
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2,
    RD_DRAIN = 2'd3
  } state_t;

  localparam int                BEAT_W     = $clog2(BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
  localparam logic [LVL_W-1:0]  BURST_LVL  = LVL_W'(BURST_LEN);
  localparam logic [LVL_W-1:0]  URGENT_LVL = LVL_W'(RD_URGENT);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FRAME_WORDS - 1);

  state_t            state;
  logic [BEAT_W-1:0] beatCnt;
  logic [ADDR_W-1:0] wrAddr;
  logic [ADDR_W-1:0] rdAddr;
  logic              lastGrantRd;
  logic              wrPend;
  logic              rdPend;
  logic [ADDR_W-1:0] memAddr;
  logic              memWe;
  logic              wrPop;
  logic              rdPush;
  logic [1:0]        grant;

  // Frame address increment, wrapping at the end of the frame
  function automatic logic [ADDR_W-1:0] nextAddr(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

  // IDLE-slot view: a pending or same-cycle frame start rewinds the base address
  logic              wrOk;
  logic              rdOk;
  logic              rdUrg;
  logic              pickRd;
  logic              pickWr;
  logic [ADDR_W-1:0] wrBase;
  logic [ADDR_W-1:0] rdBase;

  assign wrOk   = (iWR_LEVEL >= BURST_LVL);
  assign rdOk   = (iRD_SPACE >= BURST_LVL);
  assign rdUrg  = (iRD_SPACE >= URGENT_LVL);
  assign wrBase = (wrPend || iWR_FRAME_START) ? '0 : wrAddr;
  assign rdBase = (rdPend || iRD_FRAME_START) ? '0 : rdAddr;
  // Urgent read wins; if both are eligible, the side not served last time wins
  assign pickRd = rdUrg || (rdOk && (!wrOk || !lastGrantRd));
  assign pickWr = !rdUrg && wrOk && (!rdOk || lastGrantRd);

  // Burst sequencer: one state register, all control outputs registered
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state       <= IDLE;
      beatCnt     <= '0;
      wrAddr      <= '0;
      rdAddr      <= '0;
      lastGrantRd <= 1'b1;
      wrPend      <= 1'b0;
      rdPend      <= 1'b0;
      memAddr     <= '0;
      memWe       <= 1'b0;
      wrPop       <= 1'b0;
      rdPush      <= 1'b0;
      grant       <= 2'b00;
    end else begin
      if (iWR_FRAME_START) wrPend <= 1'b1;
      if (iRD_FRAME_START) rdPend <= 1'b1;
      rdPush <= 1'b0;
      case (state)
        IDLE: begin
          wrPend  <= 1'b0;
          rdPend  <= 1'b0;
          wrAddr  <= wrBase;
          rdAddr  <= rdBase;
          beatCnt <= '0;
          if (pickRd) begin
            state       <= RD_BURST;
            grant       <= 2'b10;
            memAddr     <= rdBase;
            rdAddr      <= nextAddr(rdBase);
            lastGrantRd <= 1'b1;
          end else if (pickWr) begin
            state       <= WR_BURST;
            grant       <= 2'b01;
            memAddr     <= wrBase;
            wrAddr      <= nextAddr(wrBase);
            memWe       <= 1'b1;
            wrPop       <= 1'b1;
            lastGrantRd <= 1'b0;
          end
        end
        WR_BURST: begin
          if (beatCnt == LAST_BEAT) begin
            state <= IDLE;
            grant <= 2'b00;
            memWe <= 1'b0;
            wrPop <= 1'b0;
          end else begin
            beatCnt <= beatCnt + 1'b1;
            memAddr <= wrAddr;
            wrAddr  <= nextAddr(wrAddr);
          end
        end
        RD_BURST: begin
          // The word addressed this cycle comes back next cycle
          rdPush <= 1'b1;
          if (beatCnt == LAST_BEAT) begin
            state <= RD_DRAIN;
          end else begin
            beatCnt <= beatCnt + 1'b1;
            memAddr <= rdAddr;
            rdAddr  <= nextAddr(rdAddr);
          end
        end
        RD_DRAIN: begin
          state <= IDLE;
          grant <= 2'b00;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign oWR_POP    = wrPop;
  assign oMEM_WE    = memWe;
  assign oMEM_ADDR  = memAddr;
  assign oMEM_WDATA = memWe ? iWR_DATA : '0;
  assign oRD_PUSH   = rdPush;
  assign oRD_DATA   = rdPush ? iMEM_RDATA : '0;
  assign oGRANT     = grant;
  assign oDBG_STATE = state;

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// tb_frame_mem_arbiter: directed steps with a write/read scoreboard for
// frame_mem_arbiter. This instance uses a 20-word frame so that address wrap is reachable.
module tb_frame_mem_arbiter;

  localparam int ADDR_W      = 19;
  localparam int DATA_W      = 16;
  localparam int LVL_W       = 10;
  localparam int BURST_LEN   = 8;
  localparam int FRAME_WORDS = 20;
  localparam int RD_URGENT   = 768;

  // clock / reset
  logic iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  logic              iRST;
  logic [LVL_W-1:0]  iWR_LEVEL;
  logic [LVL_W-1:0]  iRD_SPACE;
  logic [DATA_W-1:0] iWR_DATA;
  logic              iWR_FRAME_START;
  logic              iRD_FRAME_START;
  logic [DATA_W-1:0] iMEM_RDATA;
  logic              oWR_POP;
  logic              oRD_PUSH;
  logic [DATA_W-1:0] oRD_DATA;
  logic [ADDR_W-1:0] oMEM_ADDR;
  logic              oMEM_WE;
  logic [DATA_W-1:0] oMEM_WDATA;
  logic [1:0]        oGRANT;
  logic [1:0]        oDBG_STATE;

  frame_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LVL_W(LVL_W), .BURST_LEN(BURST_LEN),
    .FRAME_WORDS(FRAME_WORDS), .RD_URGENT(RD_URGENT)
  ) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iWR_LEVEL(iWR_LEVEL), .iWR_DATA(iWR_DATA), .oWR_POP(oWR_POP),
    .iWR_FRAME_START(iWR_FRAME_START),
    .iRD_SPACE(iRD_SPACE), .oRD_PUSH(oRD_PUSH), .oRD_DATA(oRD_DATA),
    .iRD_FRAME_START(iRD_FRAME_START),
    .oMEM_ADDR(oMEM_ADDR), .oMEM_WE(oMEM_WE), .oMEM_WDATA(oMEM_WDATA),
    .iMEM_RDATA(iMEM_RDATA), .oGRANT(oGRANT), .oDBG_STATE(oDBG_STATE)
  );

  // environment: show-ahead write FIFO head (A000 + pop count) and the RAM
  logic [15:0] wrSeq = 16'd0;
  always @(posedge iCLK) if (oWR_POP) wrSeq <= wrSeq + 16'd1;
  assign iWR_DATA = 16'hA000 + wrSeq;

  logic [15:0] ram [0:31];
  logic [15:0] ramQ;
  logic        preloadReq;
  always @(posedge iCLK) begin
    if (preloadReq) begin
      for (int k = 0; k < 32; k++) ram[k] <= 16'(k);
    end else if (oMEM_WE) begin
      ram[oMEM_ADDR[4:0]] <= oMEM_WDATA;
    end
    ramQ <= ram[oMEM_ADDR[4:0]];
  end
  assign iMEM_RDATA = ramQ;

  // scoreboard
  logic [34:0] expWr[$];
  logic [18:0] expRdAddr[$];
  logic [1:0]  expGrant[$];
  logic [15:0] shadow [0:31];
  logic [18:0] mWrA, mRdA, lastAddr;
  logic [15:0] mSeq;
  int          testsRun  = 0;
  int          failCount = 0;

  // monitor state
  bit          monOn;
  logic [1:0]  prevGrant;
  int          wrBeat, rdBeat;
  bit          pendValid;
  logic [15:0] pendData;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] wrapInc(input logic [18:0] a);
    return (a == 19'(FRAME_WORDS - 1)) ? 19'd0 : a + 19'd1;
  endfunction

  // driver tasks: queue the expected effect of one granted burst
  task automatic pushWrite();
    logic [15:0] d;
    for (int i = 0; i < BURST_LEN; i++) begin
      d = 16'hA000 + mSeq;
      expWr.push_back({mWrA, d});
      shadow[mWrA[4:0]] = d;
      lastAddr = mWrA;
      mSeq++;
      mWrA = wrapInc(mWrA);
    end
    expGrant.push_back(2'b01);
  endtask

  task automatic pushRead();
    for (int i = 0; i < BURST_LEN; i++) begin
      expRdAddr.push_back(mRdA);
      lastAddr = mRdA;
      mRdA = wrapInc(mRdA);
    end
    expGrant.push_back(2'b10);
  endtask

  // per-cycle comparison of DUT activity against the queues
  task automatic monitorStep();
    logic [34:0] ew;
    logic [18:0] ea;
    logic [1:0]  eg;
    bit          newPend;
    logic [15:0] newData;
    newPend = 1'b0;
    newData = 16'd0;
    if (prevGrant == 2'b00 && oGRANT != 2'b00) begin
      check("grant_queue", expGrant.size() != 0, 1);
      if (expGrant.size() != 0) begin
        eg = expGrant.pop_front();
        check("grant_order", oGRANT, eg);
      end
    end
    prevGrant = oGRANT;
    check("wr_pop_vs_we", oWR_POP, oMEM_WE);
    if (oGRANT == 2'b01) wrBeat++; else wrBeat = 0;
    if (wrBeat > BURST_LEN) check("wr_burst_len", wrBeat, BURST_LEN);
    if (oGRANT == 2'b01) check("wr_we", oMEM_WE, 1);
    if (oMEM_WE) begin
      check("wr_grant", oGRANT, 2'b01);
      check("wr_queue", expWr.size() != 0, 1);
      if (expWr.size() != 0) begin
        ew = expWr.pop_front();
        check("wr_addr", oMEM_ADDR, ew[34:16]);
        check("wr_data", oMEM_WDATA, ew[15:0]);
      end
    end
    if (oGRANT == 2'b10) rdBeat++; else rdBeat = 0;
    if (rdBeat > BURST_LEN + 1) check("rd_burst_len", rdBeat, BURST_LEN + 1);
    if (rdBeat >= 1 && rdBeat <= BURST_LEN) begin
      check("rd_we", oMEM_WE, 0);
      check("rd_queue", expRdAddr.size() != 0, 1);
      if (expRdAddr.size() != 0) begin
        ea = expRdAddr.pop_front();
        check("rd_addr", oMEM_ADDR, ea);
        newPend = 1'b1;
        newData = shadow[ea[4:0]];
      end
    end
    check("rd_push", oRD_PUSH, pendValid);
    if (pendValid) check("rd_data", oRD_DATA, pendData);
    pendValid = newPend;
    pendData  = newData;
  endtask

  task automatic cycle();
    @(negedge iCLK);
    if (monOn) begin
      monitorStep();
    end else begin
      prevGrant = 2'b00;
      wrBeat    = 0;
      rdBeat    = 0;
      pendValid = 1'b0;
    end
  endtask

  task automatic doReset(input logic [LVL_W-1:0] wl, input logic [LVL_W-1:0] rs);
    monOn = 1'b0;
    iRST = 1'b1;
    iWR_LEVEL = wl;
    iRD_SPACE = rs;
    iWR_FRAME_START = 1'b0;
    iRD_FRAME_START = 1'b0;
    repeat (2) begin
      cycle();
      check("reset_outputs", {oWR_POP, oRD_PUSH, oRD_DATA, oMEM_ADDR, oMEM_WE,
                              oMEM_WDATA, oGRANT, oDBG_STATE}, 0);
    end
    expWr.delete();
    expRdAddr.delete();
    expGrant.delete();
    iRST  = 1'b0;
    mWrA  = 19'd0;
    mRdA  = 19'd0;
    monOn = 1'b1;
  endtask

  // Let n bursts start (bounded), then remove eligibility and let the last one finish
  task automatic runBursts(input int n, input int gap, input bit midWrPulse);
    int rises, cyc, lastRise;
    logic [1:0] pg;
    rises = 0;
    cyc = 0;
    lastRise = -1;
    pg = oGRANT;
    while (rises < n && cyc < 300) begin
      cycle();
      cyc++;
      iRD_FRAME_START = 1'b0;
      if (pg == 2'b00 && oGRANT != 2'b00) begin
        rises++;
        if (gap > 0 && lastRise >= 0) check("burst_spacing", cyc - lastRise, gap);
        lastRise = cyc;
      end
      pg = oGRANT;
    end
    check("burst_count", rises, n);
    if (midWrPulse) begin
      repeat (3) cycle();
      iWR_FRAME_START = 1'b1;
      cycle();
      iWR_FRAME_START = 1'b0;
    end
    iWR_LEVEL = '0;
    iRD_SPACE = '0;
    repeat (BURST_LEN + 4) cycle();
    check("idle_grant", oGRANT, 0);
    check("addr_hold", oMEM_ADDR, lastAddr);
    check("sb_drain", expWr.size() + expRdAddr.size() + expGrant.size(), 0);
  endtask

  initial begin
    int rises;
    iRST = 1'b1;
    iWR_LEVEL = '1;
    iRD_SPACE = '1;
    iWR_FRAME_START = 1'b0;
    iRD_FRAME_START = 1'b0;
    monOn = 1'b0;
    mSeq = 16'd0;
    lastAddr = 19'd0;
    preloadReq = 1'b1;
    for (int k = 0; k < 32; k++) shadow[k] = 16'(k);
    cycle();
    preloadReq = 1'b0;

    // 1: reset with levels at max, then first grant goes to write
    doReset('1, '1);
    iWR_LEVEL = '1;
    iRD_SPACE = 10'd100;
    pushWrite();
    runBursts(1, 0, 1'b0);

    // 2: write only, back-to-back bursts every BURST_LEN+1 cycles
    doReset('0, '0);
    iWR_LEVEL = 10'd8;
    iRD_SPACE = 10'd0;
    pushWrite();
    pushWrite();
    runBursts(2, BURST_LEN + 1, 1'b0);

    // 3: read latency on a preloaded RAM, bursts every BURST_LEN+2 cycles
    doReset('0, '0);
    preloadReq = 1'b1;
    for (int k = 0; k < 32; k++) shadow[k] = 16'(k);
    cycle();
    preloadReq = 1'b0;
    iRD_SPACE = 10'd100;
    pushRead();
    pushRead();
    runBursts(2, BURST_LEN + 2, 1'b0);
    // read frame start arriving in the arbitration cycle applies at once
    mRdA = 19'd0;
    pushRead();
    iRD_SPACE = 10'd100;
    iRD_FRAME_START = 1'b1;
    runBursts(1, 0, 1'b0);

    // 4: fairness W,R,W,R then urgency R,R,R
    doReset('0, '0);
    iWR_LEVEL = '1;
    iRD_SPACE = 10'd100;
    pushWrite();
    pushRead();
    pushWrite();
    pushRead();
    runBursts(4, 0, 1'b0);
    iWR_LEVEL = '1;
    iRD_SPACE = 10'd800;
    pushRead();
    pushRead();
    pushRead();
    runBursts(3, BURST_LEN + 2, 1'b0);

    // 5: write address wrap, frame start in the middle of the third burst
    doReset('0, '0);
    iWR_LEVEL = 10'd8;
    iRD_SPACE = 10'd0;
    pushWrite();
    pushWrite();
    pushWrite();
    runBursts(3, BURST_LEN + 1, 1'b1);
    mWrA = 19'd0;
    pushWrite();
    iWR_LEVEL = 10'd8;
    runBursts(1, 0, 1'b0);

    // 6: reset during RD_BURST beat 4 drops the in-flight word
    doReset('0, '0);
    iRD_SPACE = 10'd100;
    pushRead();
    runBursts(1, 0, 1'b0);
    monOn = 1'b0;
    iRD_SPACE = 10'd100;
    rises = 0;
    for (int c = 0; c < 40 && rises == 0; c++) begin
      cycle();
      if (oGRANT == 2'b10) rises = 1;
    end
    check("rd2_grant", oGRANT, 2'b10);
    check("rd2_first_addr", oMEM_ADDR, 8);
    repeat (4) cycle();
    check("rd2_push_beat4", oRD_PUSH, 1);
    doReset('0, '0);
    cycle();
    check("post_reset_push", oRD_PUSH, 0);
    iRD_SPACE = 10'd100;
    pushRead();
    runBursts(1, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
